rdma_framer: RTL and testbench
==============================

# rdma_framer

Packet framer that sits directly downstream of the AXI-MM-to-stream write converter. It consumes the per-burst address stream and the write-data stream and emits one framed AXI-Stream packet per burst. Each packet is a single 51-byte header beat (magic, sequence number, target address, channel ID) followed by the burst's data beats unmodified. The output feeds the transport/MAC stage.

## Interface
- DATA_WIDTH, 512, stream data width in bits; fixed at 512 (the header occupies one beat)
- ADDR_WIDTH, 64, address stream width
- CHANNEL_ID, 8'h00, 8-bit constant written into header byte 16
- MAX_BEATS, 256, maximum data beats per packet before a TLAST is forced
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- S_ADDR_TDATA  in  ADDR_WIDTH  burst target address
- S_ADDR_TVALID  in  1
- S_ADDR_TREADY  out  1
- S_DATA_TDATA  in  DATA_WIDTH  write data
- S_DATA_TKEEP  in  DATA_WIDTH/8  byte enables
- S_DATA_TLAST  in  1  last beat of burst
- S_DATA_TVALID  in  1
- S_DATA_TREADY  out  1
- M_AXIS_TDATA  out  DATA_WIDTH  framed output
- M_AXIS_TKEEP  out  DATA_WIDTH/8
- M_AXIS_TLAST  out  1
- M_AXIS_TVALID  out  1
- M_AXIS_TREADY  in  1
- overflow_err  out  1  sticky: a burst exceeded MAX_BEATS
- pkt_count  out  32  packets completed (stats)
- beat_count  out  32  data beats forwarded (stats)

## Operation
- FSM states: IDLE, HDR, DATA.
- IDLE: S_ADDR_TREADY=1. S_DATA_TREADY=0 and M_AXIS_TVALID=0. On an S_ADDR handshake, latch the address into addr_q and go to HDR.
- HDR: M_AXIS_TVALID=1. M_AXIS_TLAST=0. TKEEP = low 51 bits set (64'h0007_FFFF_FFFF_FFFF). S_DATA_TREADY=0.
- Header layout:
  - bytes 0-3: magic 32'h52444D41
  - bytes 4-7: seq_q
  - bytes 8-15: addr_q
  - byte 16: CHANNEL_ID
  - bytes 17-50: zero
  - bytes 51-63: zero
- On the M_AXIS handshake in HDR, go to DATA.
- DATA: combinational pass-through:
  - M_AXIS_TDATA/TKEEP/TVALID follow S_DATA.
  - S_DATA_TREADY = M_AXIS_TREADY.
  - M_AXIS_TLAST = S_DATA_TLAST OR (beat_idx == MAX_BEATS-1).
- beat_idx is 9 bits. It clears on entry to DATA and increments on each data handshake.
- On a data handshake with the output TLAST set, go to IDLE and increment seq_q.
- Forced TLAST (beat_idx == MAX_BEATS-1 and S_DATA_TLAST=0):
  - Set overflow_err.
  - Go to IDLE.
  - The remaining input beats are framed as a new packet once the next address arrives. No beats are dropped.
- seq_q is 32 bits, starts at 0, and wraps 0xFFFFFFFF -> 0.
- The address is never accepted outside IDLE. Data is never accepted outside DATA.

## Timing
- Reset values: state=IDLE, S_ADDR_TREADY=0 during reset then 1, S_DATA_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, seq_q=0, overflow_err=0, pkt_count=0, beat_count=0.
- Address handshake in cycle N puts the header valid in cycle N+1. This is a registered state transition with no combinational path from S_ADDR to M_AXIS.
- The header is held stable while M_AXIS_TREADY=0 (AXIS rule: no TVALID drop, no TDATA change).
- The data path has zero latency in DATA. Backpressure propagates combinationally.
- Minimum packet time is 3 cycles for a 1-beat burst: address, header, data. The next address is accepted the cycle after the last data handshake.
- A reset mid-packet abandons the packet. No TLAST is emitted. The downstream stage must tolerate the truncation.

## Configuration
- RDMA_FRAMER_STATS_EN:
  - Defined: pkt_count increments on every final-beat handshake, including forced ones. beat_count increments on every data handshake. Both are 32-bit and wrap.
  - Undefined: both ports are tied to 0 and no counter registers are synthesised. Framing behaviour is identical.

## Test plan
- Address 0x0000_0001_2345_6780, then a 4-beat burst with TLAST on beat 4 -> outputs are:
  - header with bytes 0-3 = 52444D41, seq 0, address at bytes 8-15, TKEEP 0x0007FFFFFFFFFFFF, TLAST 0
  - then the 4 data beats unchanged, TLAST on the 4th
  - seq_q = 1 afterwards
- Header stalled by holding M_AXIS_TREADY=0 for 10 cycles -> TVALID held at 1 with TDATA constant. S_ADDR_TREADY=0 and S_DATA_TREADY=0 throughout.
- Burst of 300 beats with TLAST only on beat 300 and 2 addresses supplied -> packet 1 has 256 beats with forced TLAST and overflow_err=1. Packet 2 (seq 1) carries 44 beats.
- seq_q preloaded to 0xFFFFFFFF via back-to-back 1-beat bursts (or a force) -> next header shows seq FFFFFFFF, the following header shows 0.
- resetn asserted during beat 2 of a 4-beat burst -> next cycle TVALID=0, state IDLE, seq 0. A new address then starts a clean packet.
- With RDMA_FRAMER_STATS_EN, send 3 bursts of 1, 2 and 5 beats -> pkt_count=3, beat_count=8. Without it, both read 0.

Source files
------------

// File: rtl/rdma_framer.sv
// Frames each address+data burst as one AXI-Stream packet: a 51-byte header beat, then the data beats unmodified.
// Optional statistics counters are enabled by defining RDMA_FRAMER_STATS_EN.
module rdma_framer #(
  parameter int          DATA_WIDTH = 512,
  parameter int          ADDR_WIDTH = 64,
  parameter logic [7:0]  CHANNEL_ID = 8'h00,
  parameter int          MAX_BEATS  = 256
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   S_ADDR_TDATA,
  input  logic                    S_ADDR_TVALID,
  output logic                    S_ADDR_TREADY,
  input  logic [DATA_WIDTH-1:0]   S_DATA_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_DATA_TKEEP,
  input  logic                    S_DATA_TLAST,
  input  logic                    S_DATA_TVALID,
  output logic                    S_DATA_TREADY,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    overflow_err,
  output logic [31:0]             pkt_count,
  output logic [31:0]             beat_count
);

  localparam int                KEEP_W   = DATA_WIDTH / 8;
  localparam logic [31:0]       MAGIC    = 32'h5244_4D41;
  localparam logic [KEEP_W-1:0] HDR_KEEP = KEEP_W'(64'h0007_FFFF_FFFF_FFFF);
  localparam logic [8:0]        LAST_IDX = 9'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             seq_q;
  logic [8:0]              beat_idx;
  logic                    overflow_q;
  logic [DATA_WIDTH-1:0]   hdr;
  logic                    at_limit;
  logic                    data_hs;

  assign at_limit = (beat_idx == LAST_IDX);
  assign data_hs  = (state == DATA) && S_DATA_TVALID && M_AXIS_TREADY;

  // Header bytes 17..63 are zero; byte 0 sits in the low bits.
  always_comb begin
    hdr                      = '0;
    hdr[31:0]                = MAGIC;
    hdr[63:32]               = seq_q;
    hdr[64 +: ADDR_WIDTH]    = addr_q;
    hdr[128 +: 8]            = CHANNEL_ID;
  end

  always_comb begin
    state_nxt     = state;
    S_ADDR_TREADY = 1'b0;
    S_DATA_TREADY = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TVALID = 1'b0;
    case (state)
      IDLE: begin
        S_ADDR_TREADY = resetn;
        if (S_ADDR_TVALID && resetn) state_nxt = HDR;
      end
      HDR: begin
        M_AXIS_TDATA  = hdr;
        M_AXIS_TKEEP  = HDR_KEEP;
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) state_nxt = DATA;
      end
      DATA: begin
        M_AXIS_TDATA  = S_DATA_TDATA;
        M_AXIS_TKEEP  = S_DATA_TKEEP;
        M_AXIS_TVALID = S_DATA_TVALID;
        M_AXIS_TLAST  = S_DATA_TLAST || at_limit;
        S_DATA_TREADY = M_AXIS_TREADY;
        if (data_hs && (S_DATA_TLAST || at_limit)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      addr_q     <= '0;
      seq_q      <= '0;
      beat_idx   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && S_ADDR_TVALID) addr_q <= S_ADDR_TDATA;
      if (state == HDR && M_AXIS_TREADY) beat_idx <= '0;
      else if (data_hs)                  beat_idx <= beat_idx + 9'd1;
      if (data_hs && (S_DATA_TLAST || at_limit)) seq_q <= seq_q + 32'd1;
      // Forced split: the rest of the burst waits for the next address.
      if (data_hs && at_limit && !S_DATA_TLAST) overflow_q <= 1'b1;
    end
  end

  assign overflow_err = overflow_q;

`ifdef RDMA_FRAMER_STATS_EN
  logic [31:0] pkt_q, beat_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_q  <= '0;
      beat_q <= '0;
    end else if (data_hs) begin
      beat_q <= beat_q + 32'd1;
      if (S_DATA_TLAST || at_limit) pkt_q <= pkt_q + 32'd1;
    end
  end
  assign pkt_count  = pkt_q;
  assign beat_count = beat_q;
`else
  assign pkt_count  = '0;
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_rdma_framer.sv
// Directed bench for rdma_framer: header layout, stalls, forced split, sequence wrap, reset and stats.
module tb_rdma_framer;

  localparam logic [7:0] CH = 8'h5C;

  logic         clk = 1'b0;
  logic         resetn;
  logic [63:0]  s_addr_tdata;
  logic         s_addr_tvalid;
  logic         s_addr_tready;
  logic [511:0] s_data_tdata;
  logic [63:0]  s_data_tkeep;
  logic         s_data_tlast;
  logic         s_data_tvalid;
  logic         s_data_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic         overflow_err;
  logic [31:0]  pkt_count;
  logic [31:0]  beat_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rdma_framer #(.DATA_WIDTH(512), .ADDR_WIDTH(64), .CHANNEL_ID(CH), .MAX_BEATS(256)) dut (
    .clk(clk), .resetn(resetn),
    .S_ADDR_TDATA(s_addr_tdata), .S_ADDR_TVALID(s_addr_tvalid), .S_ADDR_TREADY(s_addr_tready),
    .S_DATA_TDATA(s_data_tdata), .S_DATA_TKEEP(s_data_tkeep), .S_DATA_TLAST(s_data_tlast),
    .S_DATA_TVALID(s_data_tvalid), .S_DATA_TREADY(s_data_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .overflow_err(overflow_err), .pkt_count(pkt_count), .beat_count(beat_count)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] hdr_of(input logic [31:0] sq, input logic [63:0] a);
    return {376'd0, CH, a, sq, 32'h5244_4D41};
  endfunction

  function automatic logic [511:0] pat(input int idx);
    return {16{32'hC0DE_0000 + 32'(idx)}};
  endfunction

  function automatic logic [63:0] kp(input int idx);
    logic [7:0] b;
    b = 8'(idx);
    return {~b, 56'hFF_FFFF_FFFF_FFFF};
  endfunction

  // Address handshake, optional header stall, then header handshake.
  task automatic send_hdr(input logic [63:0] a, input logic [31:0] sq, input int stall);
    @(negedge clk);
    s_addr_tdata = a; s_addr_tvalid = 1'b1; m_tready = 1'b1;
    #1;
    check("addr_rdy_idle", s_addr_tready, 1'b1);
    check("tvalid_idle", m_tvalid, 1'b0);
    @(negedge clk);
    s_addr_tvalid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      m_tready = 1'b0;
      #1;
      check("stall_tvalid", m_tvalid, 1'b1);
      check("stall_tdata", m_tdata, hdr_of(sq, a));
      check("stall_addr_rdy", s_addr_tready, 1'b0);
      check("stall_data_rdy", s_data_tready, 1'b0);
      @(negedge clk);
    end
    m_tready = 1'b1;
    #1;
    check("hdr_tvalid", m_tvalid, 1'b1);
    check("hdr_tdata", m_tdata, hdr_of(sq, a));
    check("hdr_tkeep", m_tkeep, 64'h0007_FFFF_FFFF_FFFF);
    check("hdr_tlast", m_tlast, 1'b0);
    check("hdr_data_rdy", s_data_tready, 1'b0);
    check("hdr_addr_rdy", s_addr_tready, 1'b0);
  endtask

  // n data beats; output TLAST expected on the n-th whether or not input marks it.
  task automatic send_data(input int base, input int n, input bit in_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_tready      = 1'b1;
      s_data_tdata  = pat(base + i);
      s_data_tkeep  = kp(base + i);
      s_data_tlast  = in_last && (i == n - 1);
      s_data_tvalid = 1'b1;
      #1;
      check("dat_tdata", m_tdata, pat(base + i));
      check("dat_tkeep", m_tkeep, kp(base + i));
      check("dat_tvalid", m_tvalid, 1'b1);
      check("dat_tlast", m_tlast, (i == n - 1));
      check("dat_rdy", s_data_tready, 1'b1);
    end
    @(negedge clk);
    s_data_tvalid = 1'b0;
    s_data_tlast  = 1'b0;
    #1;
    check("post_addr_rdy", s_addr_tready, 1'b1);
    check("post_tvalid", m_tvalid, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; s_addr_tdata = '0; s_addr_tvalid = 1'b0;
    s_data_tdata = '0; s_data_tkeep = '0; s_data_tlast = 1'b0; s_data_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_addr_rdy", s_addr_tready, 1'b0);
    check("rst_tvalid", m_tvalid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("init_addr_rdy", s_addr_tready, 1'b1);
    check("init_data_rdy", s_data_tready, 1'b0);
    check("init_tvalid", m_tvalid, 1'b0);
    check("init_tlast", m_tlast, 1'b0);
    check("init_ovf", overflow_err, 1'b0);
    check("init_pkt", pkt_count, 32'd0);
    check("init_beat", beat_count, 32'd0);

    // Packet 1: stalled header, one back-pressured data cycle, 4 beats.
    send_hdr(64'h0000_0001_2345_6780, 32'd0, 10);
    @(negedge clk);
    m_tready = 1'b0; s_data_tdata = pat(0); s_data_tkeep = kp(0); s_data_tvalid = 1'b1;
    #1;
    check("bp_data_rdy", s_data_tready, 1'b0);
    check("bp_tvalid", m_tvalid, 1'b1);
    check("bp_tdata", m_tdata, pat(0));
    send_data(0, 4, 1'b1);
    check("ovf_after_p1", overflow_err, 1'b0);

    // 300-beat burst splits into 256 (forced) + 44.
    send_hdr(64'hDEAD_BEEF_0000_1000, 32'd1, 0);
    send_data(0, 256, 1'b0);
    check("ovf_forced", overflow_err, 1'b1);
    send_hdr(64'hDEAD_BEEF_0000_2000, 32'd2, 0);
    send_data(256, 44, 1'b1);
    check("ovf_sticky", overflow_err, 1'b1);

    // Sequence wrap.
    @(negedge clk);
    force dut.seq_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.seq_q;
    #1;
    check("seq_preload", dut.seq_q, 32'hFFFF_FFFF);
    send_hdr(64'h0000_0000_0000_0040, 32'hFFFF_FFFF, 0);
    send_data(1000, 1, 1'b1);
    send_hdr(64'h0000_0000_0000_0080, 32'd0, 0);
    send_data(1001, 1, 1'b1);
`ifdef RDMA_FRAMER_STATS_EN
    check("pre_rst_pkt", pkt_count, 32'd5);
    check("pre_rst_beat", beat_count, 32'd306);
`else
    check("pre_rst_pkt", pkt_count, 32'd0);
    check("pre_rst_beat", beat_count, 32'd0);
`endif

    // Reset during beat 2 of a 4-beat burst.
    send_hdr(64'h0000_0000_0000_0100, 32'd1, 0);
    @(negedge clk);
    s_data_tdata = pat(2000); s_data_tkeep = kp(2000); s_data_tvalid = 1'b1;
    #1;
    check("mid_beat1", m_tdata, pat(2000));
    @(negedge clk);
    s_data_tdata = pat(2001); s_data_tkeep = kp(2001); resetn = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_tvalid", m_tvalid, 1'b0);
    check("mid_rst_tlast", m_tlast, 1'b0);
    check("mid_rst_data_rdy", s_data_tready, 1'b0);
    check("mid_rst_ovf", overflow_err, 1'b0);
    check("mid_rst_pkt", pkt_count, 32'd0);
    resetn = 1'b1; s_data_tvalid = 1'b0;
    #1;
    check("mid_rst_idle", s_addr_tready, 1'b1);

    // Clean packets after reset: 1, 2 and 5 beats.
    send_hdr(64'h0000_0000_0000_0200, 32'd0, 0);
    send_data(3000, 1, 1'b1);
    send_hdr(64'h0000_0000_0000_0300, 32'd1, 0);
    send_data(3010, 2, 1'b1);
    send_hdr(64'h0000_0000_0000_0400, 32'd2, 0);
    send_data(3020, 5, 1'b1);
`ifdef RDMA_FRAMER_STATS_EN
    check("stats_pkt", pkt_count, 32'd3);
    check("stats_beat", beat_count, 32'd8);
`else
    check("stats_pkt", pkt_count, 32'd0);
    check("stats_beat", beat_count, 32'd0);
`endif
    check("final_ovf", overflow_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
